env_edge_streamer: RTL



---
 rtl/env_edge_streamer_if.sv | 42 ++++
 rtl/env_edge_streamer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/env_edge_streamer_if.sv
// env_edge_streamer_if
//   Bundles the polygon-table read port and the edge stream between
//   env_edge_streamer (master) and its memory / consumer (slave).
//   Table read port : mem_addr_out, mem_data_in ({x,y}, x in upper half)
//   Edge stream     : edge_valid_out, edge_ready_in, x0/y0/x1/y1_out,
//                     poly_idx_out, last_edge_out
interface env_edge_streamer_if #(
    parameter int WORLD_BITS       = 32,
    parameter int MAX_NUM_POLYGONS = 16,
    parameter int ADDR_BITS        = 10
);
    logic [ADDR_BITS-1:0]                mem_addr_out;
    logic [2*WORLD_BITS-1:0]             mem_data_in;
    logic                                edge_valid_out;
    logic                                edge_ready_in;
    logic signed [WORLD_BITS-1:0]        x0_out;
    logic signed [WORLD_BITS-1:0]        y0_out;
    logic signed [WORLD_BITS-1:0]        x1_out;
    logic signed [WORLD_BITS-1:0]        y1_out;
    logic [$clog2(MAX_NUM_POLYGONS)-1:0] poly_idx_out;
    logic                                last_edge_out;

    modport master (
        output mem_addr_out,
        input  mem_data_in,
        output edge_valid_out,
        input  edge_ready_in,
        output x0_out, y0_out, x1_out, y1_out,
        output poly_idx_out,
        output last_edge_out
    );

    modport slave (
        input  mem_addr_out,
        output mem_data_in,
        input  edge_valid_out,
        output edge_ready_in,
        input  x0_out, y0_out, x1_out, y1_out,
        input  poly_idx_out,
        input  last_edge_out
    );
endinterface

// File: rtl/env_edge_streamer.sv
// env_edge_streamer
//   Walks the environment polygon table in a 1-cycle-latency BRAM and
//   streams every polygon edge (v[i] -> v[i+1], last wrapping to v[0]).
//   Record p lives at p*(MAX_NUM_VERTICES+1): header (vertex count in the
//   low bits) followed by the vertices.
// Ports:
//   clk_in, rst_in     clock, asynchronous active-high reset
//   start_in           pulse, starts a pass (ignored while busy)
//   num_polygons_in    polygon count, latched on accepted start
//   bus (master)       table read port + edge stream, see env_edge_streamer_if
//   busy_out           pass in progress
//   done_out           one-cycle pulse at end of pass
//   edge_count_out     edges handed off in the current/last pass
//                      (only with ENV_EDGE_STREAMER_STATS_EN defined)
//
// state    | meaning
// IDLE     | waiting for start
// HDR_RD   | header address on the bus
// HDR_WAIT | header data back, vertex 0 address on the bus
// V0_WAIT  | vertex 0 data back, vertex 1 address on the bus
// VN_WAIT  | vertex i data back, shifted into the edge registers
// EMIT     | edge v[i-1] -> v[i] offered, next vertex address on the bus
// CLOSE    | closing edge v[n-1] -> v[0] offered
// DONE     | end-of-pass pulse
module env_edge_streamer #(
    parameter int WORLD_BITS       = 32,
    parameter int MAX_NUM_VERTICES = 8,
    parameter int MAX_NUM_POLYGONS = 16,
    parameter int ADDR_BITS        = 10
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  start_in,
    input  logic [$clog2(MAX_NUM_POLYGONS+1)-1:0] num_polygons_in,
    env_edge_streamer_if.master                   bus,
    output logic                                  busy_out,
`ifdef ENV_EDGE_STREAMER_STATS_EN
    output logic                                  done_out,
    output logic [$clog2(MAX_NUM_POLYGONS*MAX_NUM_VERTICES+1)-1:0] edge_count_out
`else
    output logic                                  done_out
`endif
);
    localparam int NV_W      = $clog2(MAX_NUM_VERTICES+1);
    localparam int PC_W      = $clog2(MAX_NUM_POLYGONS+1);
    localparam int PI_W      = $clog2(MAX_NUM_POLYGONS);
    localparam int REC_WORDS = MAX_NUM_VERTICES + 1;
    localparam logic [NV_W-1:0] NV_MAX = NV_W'(MAX_NUM_VERTICES);

    typedef enum logic [2:0] {
        IDLE, HDR_RD, HDR_WAIT, V0_WAIT, VN_WAIT, EMIT, CLOSE, DONE
    } state_t;

    state_t state, state_nxt;

    logic [PC_W-1:0]              num_poly, poly;
    logic [ADDR_BITS-1:0]         base, mem_addr;
    logic [NV_W-1:0]              n_vert, v_idx, hdr_n, hdr_n_clamped;
    logic signed [WORLD_BITS-1:0] first_x, first_y, x0, y0, x1, y1, rd_x, rd_y;
    logic                         start_accept, skip_poly, last_poly, last_vertex;
    logic                         offering, handshake;

    assign rd_x          = bus.mem_data_in[2*WORLD_BITS-1:WORLD_BITS];
    assign rd_y          = bus.mem_data_in[WORLD_BITS-1:0];
    assign hdr_n         = bus.mem_data_in[NV_W-1:0];
    assign hdr_n_clamped = (hdr_n > NV_MAX) ? NV_MAX : hdr_n;
    assign skip_poly     = hdr_n_clamped < NV_W'(2);
    assign last_poly     = (poly + PC_W'(1)) == num_poly;
    assign last_vertex   = (v_idx + NV_W'(1)) == n_vert;
    // DONE is not busy, so a start landing on the done pulse is taken too.
    assign start_accept  = start_in && ((state == IDLE) || (state == DONE));
    assign offering      = (state == EMIT) || (state == CLOSE);
    assign handshake     = offering && bus.edge_ready_in;

    assign busy_out           = (state != IDLE) && (state != DONE);
    assign done_out           = (state == DONE);
    assign bus.edge_valid_out = offering;
    assign bus.last_edge_out  = (state == CLOSE);
    assign bus.mem_addr_out   = mem_addr;
    assign bus.x0_out         = x0;
    assign bus.y0_out         = y0;
    assign bus.x1_out         = x1;
    assign bus.y1_out         = y1;
    assign bus.poly_idx_out   = poly[PI_W-1:0];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // Addresses run one state ahead of the data they return, so the next
    // vertex read is already on the bus while an edge is being offered.
    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        unique case (state)
            IDLE, DONE: begin
                if (start_accept)
                    state_nxt = (num_polygons_in == '0) ? DONE : HDR_RD;
                else
                    state_nxt = IDLE;
            end
            HDR_RD: begin
                mem_addr  = base;
                state_nxt = HDR_WAIT;
            end
            HDR_WAIT: begin
                mem_addr = base + ADDR_BITS'(1);
                if (skip_poly) state_nxt = last_poly ? DONE : HDR_RD;
                else           state_nxt = V0_WAIT;
            end
            V0_WAIT: begin
                mem_addr  = base + ADDR_BITS'(2);
                state_nxt = VN_WAIT;
            end
            VN_WAIT: begin
                mem_addr  = base;
                state_nxt = EMIT;
            end
            EMIT: begin
                mem_addr = base + ADDR_BITS'(v_idx) + ADDR_BITS'(2);
                if (bus.edge_ready_in) state_nxt = last_vertex ? CLOSE : VN_WAIT;
            end
            CLOSE: begin
                mem_addr = base;
                if (bus.edge_ready_in) state_nxt = last_poly ? DONE : HDR_RD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // x1/y1 doubles as the "current" vertex and x0/y0 as "previous".
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            num_poly <= '0;
            poly     <= '0;
            base     <= '0;
            n_vert   <= '0;
            v_idx    <= '0;
            first_x  <= '0;
            first_y  <= '0;
            x0       <= '0;
            y0       <= '0;
            x1       <= '0;
            y1       <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start_accept) begin
                        num_poly <= num_polygons_in;
                        poly     <= '0;
                        base     <= '0;
                    end
                end
                HDR_WAIT: begin
                    n_vert <= hdr_n_clamped;
                    if (skip_poly && !last_poly) begin
                        poly <= poly + PC_W'(1);
                        base <= base + ADDR_BITS'(REC_WORDS);
                    end
                end
                V0_WAIT: begin
                    first_x <= rd_x;
                    first_y <= rd_y;
                    x1      <= rd_x;
                    y1      <= rd_y;
                    v_idx   <= '0;
                end
                VN_WAIT: begin
                    x0    <= x1;
                    y0    <= y1;
                    x1    <= rd_x;
                    y1    <= rd_y;
                    v_idx <= v_idx + NV_W'(1);
                end
                EMIT: begin
                    if (bus.edge_ready_in && last_vertex) begin
                        x0 <= x1;
                        y0 <= y1;
                        x1 <= first_x;
                        y1 <= first_y;
                    end
                end
                CLOSE: begin
                    if (bus.edge_ready_in && !last_poly) begin
                        poly <= poly + PC_W'(1);
                        base <= base + ADDR_BITS'(REC_WORDS);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ENV_EDGE_STREAMER_STATS_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)            edge_count_out <= '0;
        else if (start_accept) edge_count_out <= '0;
        else if (handshake)    edge_count_out <= edge_count_out + 1'b1;
    end
`endif
endmodule
